// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit host to 16-bit async SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W      = 18;
  localparam int unsigned DEF_WAIT_CYCLES = 1;

  localparam logic FIRST  = 1'b0;
  localparam logic SECOND = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOV
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_lat_t;

  // Reads always touch both halves; writes only the halves with a byte enabled.
  function automatic logic half_needed(logic we, logic [3:0] be, logic half);
    if (!we) return 1'b1;
    return (half == FIRST) ? (|be[3:2]) : (|be[1:0]);
  endfunction

endpackage

// File: rtl/sram_ctrl_stats.sv
// Completed host read/write counters, wrapping at 2^32.
module sram_ctrl_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_done,
  input  logic        wr_done,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else begin
      if (rd_done) rd_cnt <= rd_cnt + 32'd1;
      if (wr_done) wr_cnt <= wr_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/sram_ctrl_16bit.sv
// 32-bit host bus to 16-bit async SRAM controller, big-endian half split.
// Optional SRAM_CTRL_STATS_EN adds completed read/write counters.
module sram_ctrl_16bit
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-2:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_wr_cnt
`endif
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic              half, half_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  req_lat_t          lat, lat_nxt;
  logic [ADDR_W-2:0] lat_addr, lat_addr_nxt;

  logic              req_ready_nxt;
  logic              rsp_valid_nxt;
  logic [31:0]       rsp_rdata_nxt;
  logic [ADDR_W-1:0] sram_addr_nxt;
  logic [15:0]       sram_dq_o_nxt;
  logic              sram_dq_oe_nxt;
  logic              sram_cs_n_nxt;
  logic              sram_oe_n_nxt;
  logic              sram_we_n_nxt;
  logic              sram_ub_n_nxt;
  logic              sram_lb_n_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      half       <= FIRST;
      cnt        <= '0;
      lat        <= '0;
      lat_addr   <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      sram_addr  <= '0;
      sram_dq_o  <= 16'd0;
      sram_dq_oe <= 1'b0;
      sram_cs_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      half       <= half_nxt;
      cnt        <= cnt_nxt;
      lat        <= lat_nxt;
      lat_addr   <= lat_addr_nxt;
      req_ready  <= req_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      sram_addr  <= sram_addr_nxt;
      sram_dq_o  <= sram_dq_o_nxt;
      sram_dq_oe <= sram_dq_oe_nxt;
      sram_cs_n  <= sram_cs_n_nxt;
      sram_oe_n  <= sram_oe_n_nxt;
      sram_we_n  <= sram_we_n_nxt;
      sram_ub_n  <= sram_ub_n_nxt;
      sram_lb_n  <= sram_lb_n_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    half_nxt       = half;
    cnt_nxt        = cnt;
    lat_nxt        = lat;
    lat_addr_nxt   = lat_addr;
    req_ready_nxt  = 1'b0;
    rsp_valid_nxt  = 1'b0;
    rsp_rdata_nxt  = rsp_rdata;
    sram_addr_nxt  = sram_addr;
    sram_dq_o_nxt  = sram_dq_o;
    sram_dq_oe_nxt = 1'b0;
    sram_cs_n_nxt  = 1'b1;
    sram_oe_n_nxt  = 1'b1;
    sram_we_n_nxt  = 1'b1;
    sram_ub_n_nxt  = 1'b1;
    sram_lb_n_nxt  = 1'b1;

    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          lat_nxt      = '{we: req_we, wdata: req_wdata, be: req_be};
          lat_addr_nxt = req_addr;
          if (half_needed(req_we, req_be, FIRST)) begin
            state_nxt = SETUP;
            half_nxt  = FIRST;
          end else if (half_needed(req_we, req_be, SECOND)) begin
            state_nxt = SETUP;
            half_nxt  = SECOND;
          end else begin
            // Empty write: one idle RECOV cycle, no strobes, then ack.
            state_nxt = RECOV;
            half_nxt  = SECOND;
          end
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = RECOV;
          if (!lat.we) begin
            if (half == FIRST) rsp_rdata_nxt[31:16] = sram_dq_i;
            else               rsp_rdata_nxt[15:0]  = sram_dq_i;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RECOV: begin
        if ((half == FIRST) && half_needed(lat.we, lat.be, SECOND)) begin
          state_nxt = SETUP;
          half_nxt  = SECOND;
        end else begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Pad values for the cycle being entered.
    case (state_nxt)
      IDLE: req_ready_nxt = 1'b1;
      SETUP, STROBE: begin
        sram_addr_nxt = {lat_addr_nxt, half_nxt};
        sram_cs_n_nxt = 1'b0;
        if (lat_nxt.we) begin
          sram_dq_oe_nxt = 1'b1;
          sram_we_n_nxt  = (state_nxt != STROBE);
          sram_dq_o_nxt  = (half_nxt == FIRST) ? lat_nxt.wdata[31:16] : lat_nxt.wdata[15:0];
          sram_ub_n_nxt  = ~((half_nxt == FIRST) ? lat_nxt.be[3] : lat_nxt.be[1]);
          sram_lb_n_nxt  = ~((half_nxt == FIRST) ? lat_nxt.be[2] : lat_nxt.be[0]);
        end else begin
          sram_oe_n_nxt = 1'b0;
          sram_ub_n_nxt = 1'b0;
          sram_lb_n_nxt = 1'b0;
        end
      end
      RECOV: sram_dq_oe_nxt = lat.we && (state == STROBE);
      default: ;
    endcase
  end

`ifdef SRAM_CTRL_STATS_EN
  logic done_rd, done_wr;
  assign done_rd = rsp_valid_nxt && !lat.we;
  assign done_wr = rsp_valid_nxt && lat.we;

  sram_ctrl_stats u_stats (
    .clk     (clk),
    .rst     (rst),
    .rd_done (done_rd),
    .wr_done (done_wr),
    .rd_cnt  (stat_rd_cnt),
    .wr_cnt  (stat_wr_cnt)
  );
`endif

endmodule

// File: tb/tb_sram_ctrl_16bit.sv
// Scoreboard bench: two controllers (WAIT_CYCLES 1 and 3) sharing one behavioural SRAM.
module tb_sram_ctrl_16bit;

  logic clk, rst;
  logic sel;
  logic req_valid, req_we;
  logic [16:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [15:0] sram_dq_i;

  logic ready1, rv1, dqoe1, cs1, oe1, we1, ub1, lb1;
  logic [31:0] rdata1;
  logic [17:0] addr1;
  logic [15:0] dqo1;
  logic ready3, rv3, dqoe3, cs3, oe3, we3, ub3, lb3;
  logic [31:0] rdata3;
  logic [17:0] addr3;
  logic [15:0] dqo3;
`ifdef SRAM_CTRL_STATS_EN
  logic [31:0] srd1, swr1, srd3, swr3;
`endif

  sram_ctrl_16bit #(.ADDR_W(18), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv1), .rsp_rdata(rdata1), .sram_addr(addr1), .sram_dq_o(dqo1),
    .sram_dq_oe(dqoe1), .sram_dq_i(sram_dq_i), .sram_cs_n(cs1), .sram_oe_n(oe1),
    .sram_we_n(we1), .sram_ub_n(ub1), .sram_lb_n(lb1)
`ifdef SRAM_CTRL_STATS_EN
    , .stat_rd_cnt(srd1), .stat_wr_cnt(swr1)
`endif
  );

  sram_ctrl_16bit #(.ADDR_W(18), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(ready3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv3), .rsp_rdata(rdata3), .sram_addr(addr3), .sram_dq_o(dqo3),
    .sram_dq_oe(dqoe3), .sram_dq_i(sram_dq_i), .sram_cs_n(cs3), .sram_oe_n(oe3),
    .sram_we_n(we3), .sram_ub_n(ub3), .sram_lb_n(lb3)
`ifdef SRAM_CTRL_STATS_EN
    , .stat_rd_cnt(srd3), .stat_wr_cnt(swr3)
`endif
  );

  // The selected controller owns the shared SRAM bus.
  logic m_ready, m_cs, m_oe, m_we, m_ub, m_lb, m_dqoe;
  logic [17:0] m_addr;
  logic [15:0] m_dqo;
  assign m_ready = sel ? ready3 : ready1;
  assign m_cs    = sel ? cs3 : cs1;
  assign m_oe    = sel ? oe3 : oe1;
  assign m_we    = sel ? we3 : we1;
  assign m_ub    = sel ? ub3 : ub1;
  assign m_lb    = sel ? lb3 : lb1;
  assign m_dqoe  = sel ? dqoe3 : dqoe1;
  assign m_addr  = sel ? addr3 : addr1;
  assign m_dqo   = sel ? dqo3 : dqo1;

  typedef struct {
    bit          rd;
    bit          any;
    bit          sel;
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] sram_mem [logic [17:0]];
  logic [31:0] ref_mem  [logic [16:0]];
  int          checks, failures, cyc;
  logic [31:0] last_rd [2];
  int          n_rd [2];
  int          n_wr [2];
  bit          cs_seen, we_seen, oe_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : 16'h0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // Asynchronous SRAM: byte-masked writes while WE#/CS# low, reads while OE#/CS# low.
  task automatic sram_model();
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (!m_cs && !m_we) begin
        w = mem_rd(m_addr);
        if (!m_ub) w[15:8] = m_dqo[15:8];
        if (!m_lb) w[7:0]  = m_dqo[7:0];
        sram_mem[m_addr] = w;
      end
      sram_dq_i = (!m_cs && !m_oe) ? mem_rd(m_addr) : 16'hA5A5;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cs_seen = 0; we_seen = 0; oe_bad = 0;
      end else if (rv1 || rv3) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_source", 32'(rv3), 32'(e.sel));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("ready_with_rsp", 32'(sel ? ready3 : ready1), 32'd1);
          chk("cs_activity", 32'(cs_seen), 32'(e.any));
          chk("we_activity", 32'(we_seen), 32'(!e.rd && e.any));
          chk("strobe_rules", 32'(oe_bad), 32'd0);
          if (e.rd) begin
            chk("rdata", rv3 ? rdata3 : rdata1, e.data);
            last_rd[e.sel] = e.data;
            n_rd[e.sel]++;
          end else begin
            chk("rdata_held", rv3 ? rdata3 : rdata1, last_rd[e.sel]);
            n_wr[e.sel]++;
          end
        end
        cs_seen = 0; we_seen = 0; oe_bad = 0;
      end else begin
        if (!m_cs) cs_seen = 1;
        if (!m_we) we_seen = 1;
        if (!m_oe && (m_cs || m_dqoe)) oe_bad = 1;
        if (!m_we && (m_cs || !m_dqoe)) oe_bad = 1;
      end
    end
  endtask

  task automatic watchdog();
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input bit we, input logic [16:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input bit track);
    int n;
    int halves;
    exp_t e;
    logic [31:0] w;
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=0 required=1");
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      halves = we ? (int'(|be[3:2]) + int'(|be[1:0])) : 2;
      e.rd   = !we;
      e.any  = (halves != 0);
      e.sel  = sel;
      e.lat  = (halves == 0) ? 1 : halves * ((sel ? 3 : 1) + 2);
      e.acc  = cyc + 1;
      e.data = ref_rd(addr);
      if (we) begin
        w = ref_rd(addr);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[addr] = w;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] a;
    logic [15:0] h, l;
    bit nsel;
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; sram_dq_i = 16'hA5A5;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    n_rd[0] = 0; n_rd[1] = 0; n_wr[0] = 0; n_wr[1] = 0;
    cs_seen = 0; we_seen = 0; oe_bad = 0;

    sram_mem[18'd0] = 16'hDEAD;
    sram_mem[18'd1] = 16'hBEEF;
    ref_mem[17'd0]  = 32'hDEADBEEF;
    for (int i = 1; i < 16; i++) begin
      a = (i < 8) ? 17'(i) : 17'h1FFF0 + 17'(i - 8);
      h = 16'($urandom); l = 16'($urandom);
      sram_mem[{a, 1'b0}] = h;
      sram_mem[{a, 1'b1}] = l;
      ref_mem[a] = {h, l};
    end

    fork
      cycle_counter();
      sram_model();
      monitor();
      watchdog();
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready1", 32'(ready1), 32'd1);
    chk("rst_ready3", 32'(ready3), 32'd1);
    chk("rst_rsp_valid", 32'({rv1, rv3}), 32'd0);
    chk("rst_rdata", rdata1 | rdata3, 32'd0);
    chk("rst_strobes1", 32'({cs1, oe1, we1, ub1, lb1}), 32'h1F);
    chk("rst_strobes3", 32'({cs3, oe3, we3, ub3, lb3}), 32'h1F);
    chk("rst_dq_oe", 32'({dqoe1, dqoe3}), 32'd0);
    chk("rst_addr_dq", {14'd0, addr1} | {16'd0, dqo1}, 32'd0);

    @(posedge clk); #1;
    send(1'b0, 17'd0, 32'd0, 4'hF, 1'b1);
    send(1'b1, 17'd5, 32'h12345678, 4'hF, 1'b1);
    send(1'b0, 17'd5, 32'd0, 4'h0, 1'b1);
    send(1'b1, 17'd5, 32'hAABBCCDD, 4'b0001, 1'b1);
    send(1'b0, 17'd5, 32'd0, 4'h0, 1'b1);
    send(1'b1, 17'd5, 32'hFFFFFFFF, 4'h0, 1'b1);
    drain();
    chk("word10", 32'(mem_rd(18'd10)), 32'h1234);
    chk("word11", 32'(mem_rd(18'd11)), 32'h56DD);

    sel = 1'b1;
    send(1'b0, 17'd5, 32'd0, 4'hF, 1'b1);
    send(1'b1, 17'd6, 32'h0BADCAFE, 4'b1100, 1'b1);
    send(1'b0, 17'd6, 32'd0, 4'hF, 1'b1);
    drain();

    // Abort a write while its strobe is active.
    sel = 1'b0;
    send(1'b1, 17'd200, 32'hCAFEF00D, 4'hF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_strobe", 32'(we1), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(we1), 32'd1);
    chk("abort_cs_n", 32'(cs1), 32'd1);
    chk("abort_dq_oe", 32'(dqoe1), 32'd0);
    chk("abort_ready", 32'(ready1), 32'd1);
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    n_rd[0] = 0; n_rd[1] = 0; n_wr[0] = 0; n_wr[1] = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send(1'b0, 17'd0, 32'd0, 4'hF, 1'b1);

    for (int i = 0; i < 40; i++) begin
      nsel = 1'($urandom_range(0, 1));
      if (nsel != sel) begin
        drain();
        sel = nsel;
      end
      a = ($urandom_range(0, 1) == 0) ? 17'($urandom_range(0, 7))
                                      : 17'h1FFF0 + 17'($urandom_range(0, 7));
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 1'b1);
    end
    drain();

`ifdef SRAM_CTRL_STATS_EN
    chk("stat_rd1", srd1, 32'(n_rd[0]));
    chk("stat_wr1", swr1, 32'(n_wr[0]));
    chk("stat_rd3", srd3, 32'(n_rd[1]));
    chk("stat_wr3", swr3, 32'(n_wr[1]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
